crc_fprint_gen: RTL



---
 rtl/crc_fprint_gen.sv | 106 ++++++++++
 1 files changed

// File: rtl/crc_fprint_gen.sv
// crc_fprint_gen: folds accepted retired stores into a reflected CRC-32 and emits one fingerprint write per block
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   store_valid/address/data           retired store stream from the core
//   task_id                            key of the task being fingerprinted
//   block_size                         stores per fingerprint (0 acts as 1)
//   fprint_enable                      fingerprinting active; falling edge flushes a partial block
//   pause_reset                        discards the current partial block
//   write, write_data, write_address   fingerprint write towards crc_store_buffer
//   crc_task                           key latched at the first store of the emitted block
//   crc_ready                          block-complete pulse (same cycle as write)
//   data_write                         pulse one cycle after each accepted store
//
// Build option: define CRC_STORE_ADDR_EN to fold the store address into the CRC input word.
module crc_fprint_gen #(
  parameter int          COUNT_WIDTH              = 16,
  parameter logic [26:0] COMPARATOR_BASE          = 27'h0,
  parameter int          CRC_KEY_WIDTH            = 8,
  parameter logic [26:0] COMPARATOR_CRC_OFFSET_4X = 27'h10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     store_valid,
  input  logic [26:0]              store_address,
  input  logic [31:0]              store_data,
  input  logic [CRC_KEY_WIDTH-1:0] task_id,
  input  logic [COUNT_WIDTH-1:0]   block_size,
  input  logic                     fprint_enable,
  input  logic                     pause_reset,
  output logic                     write,
  output logic [31:0]              write_data,
  output logic [26:0]              write_address,
  output logic [CRC_KEY_WIDTH-1:0] crc_task,
  output logic                     crc_ready,
  output logic                     data_write
);
  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;
  state_t                   state_q;
  logic [31:0]              crc_q, crc_d, word, wdata_q;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d, eff_bs;
  logic [CRC_KEY_WIDTH-1:0] key_q, task_q;
  logic                     en_q, write_q, dw_q;
  logic                     in_window, acc, full, flush, first;
`ifdef CRC_STORE_ADDR_EN
  assign word = store_data ^ {5'b0, store_address};
`else
  assign word = store_data;
`endif
  // LSB-first bitwise update consumes store_data[7:0] first, matching byte-serial CRC-32
  always_comb begin
    crc_d = crc_q ^ word;
    for (int i = 0; i < 32; i++) crc_d = crc_d[0] ? ((crc_d >> 1) ^ POLY) : (crc_d >> 1);
  end
  assign in_window = store_address[26:6] == COMPARATOR_BASE[26:6];
  assign acc       = store_valid & fprint_enable & ~pause_reset & ~in_window;
  assign eff_bs    = (block_size == '0) ? {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : block_size;
  assign cnt_d     = cnt_q + 1'b1;
  assign first     = cnt_q == '0;
  // >= lets a block_size lowered below the running count close the block on the next store
  assign full      = acc & (cnt_d >= eff_bs);
  assign flush     = en_q & ~fprint_enable & ~first & ~pause_reset;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      cnt_q   <= '0;
      key_q   <= '0;
      en_q    <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      task_q  <= '0;
      dw_q    <= 1'b0;
    end else begin
      en_q    <= fprint_enable;
      dw_q    <= acc;
      write_q <= full | flush;
      if (full) begin
        wdata_q <= ~crc_d;
        task_q  <= first ? task_id : key_q;
      end else if (flush) begin
        wdata_q <= ~crc_q;
        task_q  <= key_q;
      end
      if (acc && first) key_q <= task_id;
      if (pause_reset || full || flush) begin
        crc_q   <= INIT;
        cnt_q   <= '0;
        state_q <= (full || flush) ? EMIT : IDLE;
      end else if (acc) begin
        crc_q   <= crc_d;
        cnt_q   <= cnt_d;
        state_q <= ACCUM;
      end else if (state_q == EMIT) begin
        state_q <= IDLE;
      end
    end
  assign write         = write_q;
  assign crc_ready     = write_q;
  assign write_data    = wdata_q;
  assign crc_task      = task_q;
  assign data_write    = dw_q;
  assign write_address = COMPARATOR_BASE | COMPARATOR_CRC_OFFSET_4X;
endmodule
